// File: rtl/pacman_pkg.sv
// Shared Pac-Man position/direction encodings and grid helpers, used by the
// controller and the display decoder.
package pacman_pkg;

   localparam int unsigned POS_W      = 4;
   localparam int unsigned DIR_W      = 3;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned COL_W      = 2;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NUM_BTNS   = 4;

   localparam logic ROW_TOP = 1'b0;
   localparam logic ROW_BOT = 1'b1;

   typedef enum logic [POS_W-1:0] {
      POS_A = 4'd0, POS_B = 4'd1, POS_C = 4'd3, POS_D = 4'd4,
      POS_E = 4'd5, POS_F = 4'd6, POS_G = 4'd7, POS_H = 4'd8
   } pos_e;

   typedef enum logic [DIR_W-1:0] {
      DIR_UP = 3'd0, DIR_DOWN = 3'd1, DIR_LEFT = 3'd2, DIR_RIGHT = 3'd3
   } dir_e;

   typedef struct packed {
      logic             valid;
      logic             row;
      logic [COL_W-1:0] col;
   } cell_t;

   function automatic cell_t pos_to_cell(input logic [POS_W-1:0] p);
      cell_t c;
      c = '{valid: 1'b1, row: ROW_TOP, col: 2'd0};
      case (p)
         POS_A:   c.col = 2'd0;
         POS_B:   c.col = 2'd1;
         POS_C:   c.col = 2'd2;
         POS_D:   c.col = 2'd3;
         POS_E:   begin c.row = ROW_BOT; c.col = 2'd0; end
         POS_F:   begin c.row = ROW_BOT; c.col = 2'd1; end
         POS_G:   begin c.row = ROW_BOT; c.col = 2'd2; end
         POS_H:   begin c.row = ROW_BOT; c.col = 2'd3; end
         default: c.valid = 1'b0;
      endcase
      return c;
   endfunction

   function automatic logic [POS_W-1:0] cell_to_pos(input logic row, input logic [COL_W-1:0] col);
      logic [POS_W-1:0] p;
      case ({row, col})
         3'b000:  p = POS_A;
         3'b001:  p = POS_B;
         3'b010:  p = POS_C;
         3'b011:  p = POS_D;
         3'b100:  p = POS_E;
         3'b101:  p = POS_F;
         3'b110:  p = POS_G;
         default: p = POS_H;
      endcase
      return p;
   endfunction

   // One step on the 2x4 torus-in-row grid; vertical moves saturate at the edges.
   function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p, input logic [DIR_W-1:0] d);
      cell_t c;
      c = pos_to_cell(p);
      if (!c.valid) return POS_A;
      case (d)
         DIR_UP:    c.row = ROW_TOP;
         DIR_DOWN:  c.row = ROW_BOT;
         DIR_LEFT:  c.col = c.col - 2'd1;
         DIR_RIGHT: c.col = c.col + 2'd1;
         default:   c.col = c.col;
      endcase
      return cell_to_pos(c.row, c.col);
   endfunction

endpackage

// File: rtl/pacman_ctrl_tick_gen.sv
// Free-running modulo-DIV counter; tick is high on the wrap cycle while enabled.
module tick_gen #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_c;

   assign wrap_c = (cnt_q == CNT_W'(DIV - 1));
   assign tick   = en & wrap_c;

   always_comb begin
      cnt_d = cnt_q;
      if (en) cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pacman_ctrl.sv
// Pac-Man position/heading controller with 4-digit display scan timing.
module pacman_ctrl
   import pacman_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned MOVE_DIV    = 50000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   output logic [POS_W-1:0] state,
   output logic [DIR_W-1:0] direction,
   output logic [IDX_W-1:0] idx,
   output logic [3:0]       anodes,
   output logic             move_tick
);

   logic                refresh_tick_c, step_tick_c;
   logic [NUM_BTNS-1:0] btn_c, rise_c;

   logic [NUM_BTNS-1:0] btn_prev_q, btn_prev_d;
   logic [NUM_BTNS-1:0] btn_block_q;
   logic [POS_W-1:0]    state_q, state_d;
   logic [DIR_W-1:0]    dir_q, dir_d;
   logic                move_tick_q, move_tick_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [3:0]          anodes_q, anodes_d;

   tick_gen #(.DIV(REFRESH_DIV)) u_refresh (
      .clk (clk), .rst (rst), .en (1'b1), .tick (refresh_tick_c)
   );

   tick_gen #(.DIV(MOVE_DIV)) u_move (
      .clk (clk), .rst (rst), .en (run), .tick (step_tick_c)
   );

   // btn_block_q masks buttons that were already high while reset was applied.
   assign btn_c  = {btn_up, btn_down, btn_left, btn_right};
   assign rise_c = btn_c & ~btn_prev_q & ~btn_block_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_prev_q  <= '0;
         btn_block_q <= btn_c;
         state_q     <= POS_A;
         dir_q       <= DIR_RIGHT;
         move_tick_q <= 1'b0;
         idx_q       <= '0;
         anodes_q    <= 4'b1110;
      end else begin
         btn_prev_q  <= btn_prev_d;
         btn_block_q <= '0;
         state_q     <= state_d;
         dir_q       <= dir_d;
         move_tick_q <= move_tick_d;
         idx_q       <= idx_d;
         anodes_q    <= anodes_d;
      end
   end

   // Heading and position; the step reads the heading held before this edge.
   always_comb begin
      btn_prev_d  = btn_c;
      dir_d       = dir_q;
      state_d     = state_q;
      move_tick_d = step_tick_c;
      if      (rise_c[3]) dir_d = DIR_UP;
      else if (rise_c[2]) dir_d = DIR_DOWN;
      else if (rise_c[1]) dir_d = DIR_LEFT;
      else if (rise_c[0]) dir_d = DIR_RIGHT;
      if (step_tick_c) state_d = next_pos(state_q, dir_q);
   end

   always_comb begin
      idx_d    = idx_q;
      anodes_d = anodes_q;
      if (refresh_tick_c) begin
         idx_d    = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         anodes_d = ~(4'(4'b0001 << idx_d[1:0]));
      end
   end

   assign state     = state_q;
   assign direction = dir_q;
   assign idx       = idx_q;
   assign anodes    = anodes_q;
   assign move_tick = move_tick_q;

endmodule
